// File: rtl/alu_181_serial.sv
// Bit-serial 74181-style ALU: applies the 32 74181 functions to WIDTH-bit operands,
// computing one SLICE_W-bit slice per clock (LSB first) with a registered inter-slice carry.
module alu_181_serial #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       S_selection_i,
  input  logic             mode_control_i,
  input  logic             carry_in_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] F_o,
  output logic             carry_out_o,
  output logic             zero_o,
  output logic             a_eq_b_o
);

  localparam int unsigned N          = WIDTH / SLICE_W;
  localparam int unsigned CNT_W      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE_W{1'b1}});

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         s_q, s_d;
  logic               m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   f_work_q, f_work_d;
  logic [WIDTH-1:0]   f_q, f_d;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;
  logic               aeqb_q, aeqb_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  int unsigned        base;
  logic [SLICE_W-1:0] a_sl, b_sl, x_sl, y_sl, sl_res;
  logic [SLICE_W:0]   sum;
  logic               sl_cout;
  logic [WIDTH-1:0]   f_ins;

  // Slice datapath, next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    m_d         = m_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    f_work_d    = f_work_q;
    f_d         = f_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    aeqb_d      = aeqb_q;

    base    = 32'(cnt_q) * SLICE_W;
    a_sl    = SLICE_W'(a_q >> base);
    b_sl    = SLICE_W'(b_q >> base);
    x_sl    = a_sl | (b_sl & {SLICE_W{s_q[0]}}) | (~b_sl & {SLICE_W{s_q[1]}});
    y_sl    = (a_sl & ~b_sl & {SLICE_W{s_q[2]}}) | (a_sl & b_sl & {SLICE_W{s_q[3]}});
    sum     = {1'b0, x_sl} + {1'b0, y_sl} + {{SLICE_W{1'b0}}, carry_q};
    sl_res  = m_q ? ~(x_sl ^ y_sl) : sum[SLICE_W-1:0];
    sl_cout = m_q ? 1'b0 : sum[SLICE_W];
    f_ins   = (f_work_q & ~(SLICE_MASK << base)) | (WIDTH'(sl_res) << base);

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          s_d     = S_selection_i;
          m_d     = mode_control_i;
          a_d     = A_i;
          b_d     = B_i;
          carry_d = carry_in_i;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        f_work_d = f_ins;
        carry_d  = sl_cout;
        if (cnt_q == LAST) begin
          // Final slice: publish result; carry is reported, never wrapped
          f_d     = f_ins;
          cout_d  = sl_cout;
          zero_d  = (f_ins == '0);
          aeqb_d  = &f_ins;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      m_q         <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      f_work_q    <= '0;
      f_q         <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      aeqb_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      m_q         <= m_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      f_work_q    <= f_work_d;
      f_q         <= f_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      aeqb_q      <= aeqb_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign F_o         = f_q;
  assign carry_out_o = cout_q;
  assign zero_o      = zero_q;
  assign a_eq_b_o    = aeqb_q;

endmodule

// File: tb/tb_alu_181_serial.sv
// Self-checking bench for alu_181_serial (WIDTH=16, SLICE_W=4): directed cases,
// full S/M sweep and random ops against a full-width arithmetic reference.
module tb_alu_181_serial;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  S_selection_i;
  logic        mode_control_i;
  logic        carry_in_i;
  logic [15:0] A_i;
  logic [15:0] B_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] F_o;
  logic        carry_out_o;
  logic        zero_o;
  logic        a_eq_b_o;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  alu_181_serial #(.WIDTH(16), .SLICE_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .S_selection_i  (S_selection_i),
    .mode_control_i (mode_control_i),
    .carry_in_i     (carry_in_i),
    .A_i            (A_i),
    .B_i            (B_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .F_o            (F_o),
    .carry_out_o    (carry_out_o),
    .zero_o         (zero_o),
    .a_eq_b_o       (a_eq_b_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-word reference: {carry_out, F}
  function automatic logic [16:0] ref_model(input logic [3:0] s, input logic m, input logic c,
                                            input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    x = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
    y = (a & ~b & {16{s[2]}}) | (a & b & {16{s[3]}});
    if (m) return {1'b0, ~(x ^ y)};
    return {1'b0, x} + {1'b0, y} + 17'(c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    A_i            = 16'($urandom);
    B_i            = 16'($urandom);
    S_selection_i  = 4'($urandom);
    mode_control_i = 1'($urandom);
    carry_in_i     = 1'($urandom);
  endtask

  // Full transaction: accept, measure latency, check result, handshake
  task automatic do_op(input logic [3:0] s, input logic m, input logic c,
                       input logic [15:0] a, input logic [15:0] b, input bit early);
    logic [16:0] exp;
    int unsigned lat;
    exp = ref_model(s, m, c, a, b);
    check("in_ready_idle", 32'(in_ready_o), 32'd1);
    S_selection_i  = s;
    mode_control_i = m;
    carry_in_i     = c;
    A_i            = a;
    B_i            = b;
    in_valid_i     = 1'b1;
    out_ready_i    = early;
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0;
    scramble_inputs();
    check("in_ready_busy", 32'(in_ready_o), 32'd0);
    lat = 0;
    while (!out_valid_o && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'd4);
    check("F", 32'(F_o), 32'(exp[15:0]));
    check("carry_out", 32'(carry_out_o), 32'(exp[16]));
    check("zero", 32'(zero_o), 32'(exp[15:0] == 16'h0));
    check("a_eq_b", 32'(a_eq_b_o), 32'(exp[15:0] == 16'hFFFF));
    out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_i = 1'b0;
    check("valid_drop", 32'(out_valid_o), 32'd0);
    check("ready_back", 32'(in_ready_o), 32'd1);
    check("F_hold", 32'(F_o), 32'(exp[15:0]));
  endtask

  initial begin
    logic [15:0] a, b;
    logic        c;
    logic [16:0] e;

    rst = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    S_selection_i = '0;
    mode_control_i = 1'b0;
    carry_in_i = 1'b0;
    A_i = '0;
    B_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_F", 32'(F_o), 32'd0);
    check("rst_cout", 32'(carry_out_o), 32'd0);
    check("rst_zero", 32'(zero_o), 32'd0);
    check("rst_aeqb", 32'(a_eq_b_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-computed results
    do_op(4'b1001, 1'b0, 1'b0, 16'h1234, 16'h0FFF, 1'b0);
    check("t1_F", 32'(F_o), 32'h2233);
    check("t1_cout", 32'(carry_out_o), 32'd0);
    check("t1_zero", 32'(zero_o), 32'd0);

    do_op(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    check("t2_F", 32'(F_o), 32'h0000);
    check("t2_cout", 32'(carry_out_o), 32'd1);
    check("t2_zero", 32'(zero_o), 32'd1);

    do_op(4'b0110, 1'b0, 1'b1, 16'h0005, 16'h0007, 1'b0);
    check("t3a_F", 32'(F_o), 32'hFFFE);
    check("t3a_cout", 32'(carry_out_o), 32'd0);
    do_op(4'b0110, 1'b0, 1'b0, 16'h00AA, 16'h00AA, 1'b0);
    check("t3b_F", 32'(F_o), 32'hFFFF);
    check("t3b_aeqb", 32'(a_eq_b_o), 32'd1);

    do_op(4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 1'b0);
    check("t4_F", 32'(F_o), 32'h0FF0);
    check("t4_cout", 32'(carry_out_o), 32'd0);

    // All 32 functions against the reference
    for (int i = 0; i < 32; i++) begin
      do_op(4'(i), 1'(i >> 4), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    end

    // Known arithmetic identities: A-1+cin and A+A+cin
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      do_op(4'b1111, 1'b0, c, a, b, 1'b0);
      e = {1'b0, a} + 17'h0FFFF + 17'(c);
      check("dec_F", 32'(F_o), 32'(e[15:0]));
      check("dec_cout", 32'(carry_out_o), 32'(e[16]));
      do_op(4'b1100, 1'b0, c, a, b, 1'b0);
      e = {1'b0, a} + {1'b0, a} + 17'(c);
      check("dbl_F", 32'(F_o), 32'(e[15:0]));
      check("dbl_cout", 32'(carry_out_o), 32'(e[16]));
    end

    // Backpressure in DONE with ignored requests
    S_selection_i = 4'b1001;
    mode_control_i = 1'b0;
    carry_in_i = 1'b0;
    A_i = 16'h1111;
    B_i = 16'h2222;
    in_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0;
    for (int i = 0; i < 20 && !out_valid_o; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("bp_valid", 32'(out_valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1;
      scramble_inputs();
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid_o), 32'd1);
      check("bp_in_ready", 32'(in_ready_o), 32'd0);
      check("bp_hold_F", 32'(F_o), 32'h3333);
      check("bp_hold_zero", 32'(zero_o), 32'd0);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("bp_no_queue_valid", 32'(out_valid_o), 32'd0);
      check("bp_no_queue_ready", 32'(in_ready_o), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end

    // Reset while slice 2 is pending
    S_selection_i = 4'b1001;
    mode_control_i = 1'b0;
    carry_in_i = 1'b1;
    A_i = 16'h4321;
    B_i = 16'h1111;
    in_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mrst_in_ready", 32'(in_ready_o), 32'd1);
    check("mrst_out_valid", 32'(out_valid_o), 32'd0);
    check("mrst_F", 32'(F_o), 32'd0);
    check("mrst_cout", 32'(carry_out_o), 32'd0);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("mrst_no_output", 32'(out_valid_o), 32'd0);
    end
    do_op(4'b1001, 1'b0, 1'b1, 16'h4321, 16'h1111, 1'b0);
    check("mrst_after_F", 32'(F_o), 32'h5433);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      do_op(4'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
